// File: rtl/rf_write_arbiter.sv
// Register-file write-port arbiter: writeback has fixed priority, and a starvation counter lets the multi-cycle unit through.
// Optional feature macro RF_WARB_FWD_EN adds a forwarding lookup on the in-flight write.
module rf_write_arbiter #(
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        wb_valid_i,
    input  logic [4:0]  wb_rd_i,
    input  logic [31:0] wb_data_i,
    output logic        wb_ready_o,
    input  logic        mc_valid_i,
    input  logic [4:0]  mc_rd_i,
    input  logic [31:0] mc_data_i,
    output logic        mc_ready_o,
    output logic        rf_we_o,
    output logic [4:0]  rf_rd_o,
    output logic [31:0] rf_data_o,
`ifdef RF_WARB_FWD_EN
    input  logic [4:0]  fwd_rs_i,
    output logic        fwd_hit_o,
    output logic [31:0] fwd_data_o,
`endif
    output logic        starved_o
);

    localparam logic [3:0] LIMIT_C = 4'(STARVE_LIMIT);

    logic        grant_wb_s;
    logic        grant_mc_s;
    logic [4:0]  sel_rd_s;
    logic [31:0] sel_data_s;
    logic [3:0]  count_r;
    logic [3:0]  count_nxt_s;
    logic        starved_r;
    logic        rf_we_r;
    logic [4:0]  rf_rd_r;
    logic [31:0] rf_data_r;

    // Grant selection: a starved mc beats wb, otherwise wb beats mc.
    always_comb begin
        grant_wb_s = 1'b0;
        grant_mc_s = 1'b0;
        if (starved_r && mc_valid_i) begin
            grant_mc_s = 1'b1;
        end else if (wb_valid_i) begin
            grant_wb_s = 1'b1;
        end else if (mc_valid_i) begin
            grant_mc_s = 1'b1;
        end else begin
            grant_wb_s = 1'b0;
            grant_mc_s = 1'b0;
        end
    end

    // Payload mux for the granted requester.
    always_comb begin
        sel_rd_s   = 5'd0;
        sel_data_s = 32'd0;
        if (grant_mc_s) begin
            sel_rd_s   = mc_rd_i;
            sel_data_s = mc_data_i;
        end else begin
            sel_rd_s   = wb_rd_i;
            sel_data_s = wb_data_i;
        end
    end

    // Next starvation count: counts stalled mc cycles, saturating at the limit.
    always_comb begin
        count_nxt_s = 4'd0;
        if (mc_valid_i && !grant_mc_s) begin
            if (count_r >= LIMIT_C) begin
                count_nxt_s = LIMIT_C;
            end else begin
                count_nxt_s = count_r + 4'd1;
            end
        end else begin
            count_nxt_s = 4'd0;
        end
    end

    // Starvation state and the registered write port.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_r   <= 4'd0;
            starved_r <= 1'b0;
            rf_we_r   <= 1'b0;
            rf_rd_r   <= 5'd0;
            rf_data_r <= 32'd0;
        end else begin
            count_r   <= count_nxt_s;
            // Kept as a flag so starved_o comes straight from a flop.
            starved_r <= (count_nxt_s == LIMIT_C);
            if (grant_wb_s || grant_mc_s) begin
                rf_we_r   <= (sel_rd_s != 5'd0);
                rf_rd_r   <= sel_rd_s;
                rf_data_r <= sel_data_s;
            end else begin
                rf_we_r   <= 1'b0;
            end
        end
    end

    assign wb_ready_o = grant_wb_s;
    assign mc_ready_o = grant_mc_s;
    assign rf_we_o    = rf_we_r;
    assign rf_rd_o    = rf_rd_r;
    assign rf_data_o  = rf_data_r;
    assign starved_o  = starved_r;

`ifdef RF_WARB_FWD_EN
    logic fwd_hit_s;

    // Lookup against the write currently on the port; x0 never forwards.
    always_comb begin
        fwd_hit_s = 1'b0;
        if (rf_we_r && (fwd_rs_i == rf_rd_r) && (fwd_rs_i != 5'd0)) begin
            fwd_hit_s = 1'b1;
        end else begin
            fwd_hit_s = 1'b0;
        end
    end

    assign fwd_hit_o  = fwd_hit_s;
    assign fwd_data_o = fwd_hit_s ? rf_data_r : 32'd0;
`endif

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Randomized self-checking bench for rf_write_arbiter against a transaction-level model of grants and writes.
module tb_rf_write_arbiter;
    localparam int LIM = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        wb_valid, mc_valid;
    logic [4:0]  wb_rd, mc_rd;
    logic [31:0] wb_data, mc_data;
    logic        wb_ready, mc_ready, rf_we, starved;
    logic [4:0]  rf_rd;
    logic [31:0] rf_data;
`ifdef RF_WARB_FWD_EN
    logic [4:0]  fwd_rs;
    logic        fwd_hit;
    logic [31:0] fwd_data;
`endif

    always #5 clk = ~clk;

    rf_write_arbiter #(.STARVE_LIMIT(LIM)) dut (
        .clk(clk), .rst_n(rst_n),
        .wb_valid_i(wb_valid), .wb_rd_i(wb_rd), .wb_data_i(wb_data), .wb_ready_o(wb_ready),
        .mc_valid_i(mc_valid), .mc_rd_i(mc_rd), .mc_data_i(mc_data), .mc_ready_o(mc_ready),
        .rf_we_o(rf_we), .rf_rd_o(rf_rd), .rf_data_o(rf_data),
`ifdef RF_WARB_FWD_EN
        .fwd_rs_i(fwd_rs), .fwd_hit_o(fwd_hit), .fwd_data_o(fwd_data),
`endif
        .starved_o(starved)
    );

    int          n_vec = 0;
    int          n_err = 0;
    int          mc_wait;
    logic        e_gwb, e_gmc, e_we;
    logic [4:0]  e_rd;
    logic [31:0] e_data;
    logic        obs_mc_ready;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        mc_wait = 0;
        e_we    = 1'b0;
        e_rd    = 5'd0;
        e_data  = 32'd0;
    endtask

    // One clock: check handshake mid-cycle, advance the model, check the write port after the edge.
    task automatic step();
        @(negedge clk);
        e_gmc = mc_valid && ((mc_wait >= LIM) || !wb_valid);
        e_gwb = wb_valid && !e_gmc;
        obs_mc_ready = mc_ready;
        chk("wb_ready", {31'd0, wb_ready}, {31'd0, e_gwb});
        chk("mc_ready", {31'd0, mc_ready}, {31'd0, e_gmc});
        chk("starved", {31'd0, starved}, {31'd0, mc_wait >= LIM});
        if (e_gwb) begin
            e_we = (wb_rd != 5'd0); e_rd = wb_rd; e_data = wb_data;
        end else if (e_gmc) begin
            e_we = (mc_rd != 5'd0); e_rd = mc_rd; e_data = mc_data;
        end else begin
            e_we = 1'b0;
        end
        if (mc_valid && !e_gmc) mc_wait = (mc_wait + 1 > LIM) ? LIM : mc_wait + 1;
        else mc_wait = 0;
        @(posedge clk);
        #1;
        chk("rf_we", {31'd0, rf_we}, {31'd0, e_we});
        chk("rf_rd", {27'd0, rf_rd}, {27'd0, e_rd});
        chk("rf_data", rf_data, e_data);
`ifdef RF_WARB_FWD_EN
        fwd_rs = ($urandom_range(0, 1) == 0) ? e_rd : 5'($urandom);
        #1;
        chk("fwd_hit", {31'd0, fwd_hit}, {31'd0, e_we && (fwd_rs == e_rd) && (fwd_rs != 5'd0)});
        chk("fwd_data", fwd_data, (e_we && (fwd_rs == e_rd) && (fwd_rs != 5'd0)) ? e_data : 32'd0);
`endif
    endtask

    initial begin
        rst_n = 1'b0;
        wb_valid = 1'b0; wb_rd = 5'd0; wb_data = 32'd0;
        mc_valid = 1'b0; mc_rd = 5'd0; mc_data = 32'd0;
`ifdef RF_WARB_FWD_EN
        fwd_rs = 5'd0;
`endif
        model_reset();
        #12;
        chk("rst_we", {31'd0, rf_we}, 32'd0);
        chk("rst_rd", {27'd0, rf_rd}, 32'd0);
        chk("rst_data", rf_data, 32'd0);
        chk("rst_starved", {31'd0, starved}, 32'd0);
        chk("rst_ready", {30'd0, wb_ready, mc_ready}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Lone writeback
        wb_valid = 1'b1; wb_rd = 5'd5; wb_data = 32'hDEADBEEF;
        step();
        chk("lone_rd", {27'd0, rf_rd}, 32'd5);
        chk("lone_data", rf_data, 32'hDEADBEEF);
        wb_valid = 1'b0;
        step();

        // Contention, then mc drains once wb goes idle
        wb_valid = 1'b1; wb_rd = 5'd3; wb_data = 32'h33;
        mc_valid = 1'b1; mc_rd = 5'd4; mc_data = 32'h44;
        step();
        chk("cont_rd", {27'd0, rf_rd}, 32'd3);
        wb_valid = 1'b0;
        step();
        chk("cont_mc_rd", {27'd0, rf_rd}, 32'd4);
        mc_valid = 1'b0;
        step();

        // Starvation under continuous wb traffic
        wb_valid = 1'b1; wb_rd = 5'd9; mc_valid = 1'b1; mc_rd = 5'd10; mc_data = 32'hA0;
        for (int i = 0; i <= LIM; i++) begin
            wb_data = 32'(i);
            step();
            chk("starve_mc_ready", {31'd0, obs_mc_ready}, {31'd0, i == LIM});
        end
        mc_rd = 5'd11;
        step();

        // x0 writes: wb x0 stalls mc; mc's x0 grant clears its count
        wb_rd = 5'd0; wb_data = 32'h1234; mc_rd = 5'd0;
        for (int i = 0; i < LIM + 3; i++) step();
        wb_valid = 1'b0; mc_valid = 1'b0;
        step();

        // Reset mid-stream with a live write and count at 3
        wb_valid = 1'b1; wb_rd = 5'd6; wb_data = 32'h66; mc_valid = 1'b1; mc_rd = 5'd7;
        for (int i = 0; i < 3; i++) step();
        rst_n = 1'b0;
        #1;
        chk("mrst_we", {31'd0, rf_we}, 32'd0);
        chk("mrst_rd", {27'd0, rf_rd}, 32'd0);
        chk("mrst_data", rf_data, 32'd0);
        chk("mrst_starved", {31'd0, starved}, 32'd0);
        model_reset();
        wb_valid = 1'b0; mc_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        mc_valid = 1'b1; mc_rd = 5'd8; mc_data = 32'h88;
        step();
        chk("post_rst_mc", {31'd0, obs_mc_ready}, 32'd1);
        mc_valid = 1'b0;

        // Randomized traffic; requesters hold payload until accepted
        for (int i = 0; i < 400; i++) begin
            step();
            if (!wb_valid || e_gwb) begin
                wb_valid = ($urandom_range(0, 3) != 0);
                wb_rd    = ($urandom_range(0, 5) == 0) ? 5'd0 : 5'($urandom);
                wb_data  = $urandom;
            end
            if (!mc_valid || e_gmc) begin
                mc_valid = ($urandom_range(0, 1) != 0);
                mc_rd    = ($urandom_range(0, 5) == 0) ? 5'd0 : 5'($urandom);
                mc_data  = $urandom;
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
